// File: rtl/mem_controller_pkg.sv
// Shared types, constants and address decode for the MEM-stage bus master
// and its SRAM port sub-blocks.
package mem_controller_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned SRAM_AW = 20;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned USE_W   = 2;

  localparam logic [BE_W-1:0]  BE_NONE  = 4'b1111;

  localparam logic [USE_W-1:0] USE_BASE = 2'd0;
  localparam logic [USE_W-1:0] USE_EXT  = 2'd1;
  localparam logic [USE_W-1:0] USE_UART = 2'd2;

  localparam logic [ADDR_W-1:0] SRAM_MASK        = 32'hFFC0_0000;
  localparam logic [ADDR_W-1:0] BASE_RAM_BASE    = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] EXT_RAM_BASE     = 32'h8040_0000;
  localparam logic [ADDR_W-1:0] UART_DATA_ADDR   = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] UART_STAT_ADDR   = 32'h1000_0005;
  localparam logic [ADDR_W-1:0] UART_REGION_MASK = 32'hF000_0000;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SRAM_RD      = 3'd1,
    ST_SRAM_WR      = 3'd2,
    ST_UART_RD      = 3'd3,
    ST_UART_WR      = 3'd4,
    ST_UART_WR_WAIT = 3'd5,
    ST_DONE         = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    TGT_BASE      = 3'd0,
    TGT_EXT       = 3'd1,
    TGT_UART_DATA = 3'd2,
    TGT_UART_STAT = 3'd3,
    TGT_NONE      = 3'd4
  } target_e;

  typedef struct packed {
    logic                we;
    logic [SRAM_AW-1:0]  addr;
    logic [BE_W-1:0]     be_n;
    logic [DATA_W-1:0]   wdata;
  } sram_cmd_t;

  function automatic target_e decode_target(input logic [ADDR_W-1:0] addr,
                                            input logic              status_en);
    if ((addr & SRAM_MASK) == BASE_RAM_BASE) return TGT_BASE;
    if ((addr & SRAM_MASK) == EXT_RAM_BASE)  return TGT_EXT;
    if (addr == UART_DATA_ADDR)              return TGT_UART_DATA;
    if (status_en && (addr == UART_STAT_ADDR)) return TGT_UART_STAT;
    return TGT_NONE;
  endfunction

  // Unmapped addresses in the UART window report as UART so the loader reads 0 from uart_rd.
  function automatic logic [USE_W-1:0] use_of(input target_e           tgt,
                                              input logic [ADDR_W-1:0] addr);
    case (tgt)
      TGT_BASE:                    return USE_BASE;
      TGT_EXT:                     return USE_EXT;
      TGT_UART_DATA, TGT_UART_STAT: return USE_UART;
      default: return ((addr & UART_REGION_MASK) == (UART_DATA_ADDR & UART_REGION_MASK))
                      ? USE_UART : USE_BASE;
    endcase
  endfunction

endpackage

// File: rtl/mem_controller_sram_port.sv
// One SRAM channel: registered strobes, write-data drive enable, access
// counter and read-data capture register.
module mem_controller_sram_port
  import mem_controller_pkg::*;
#(
  parameter int unsigned WAIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  sram_cmd_t          cmd_i,
  input  logic               clr_i,
  input  logic [DATA_W-1:0]  bus_rdata_i,
  output logic               done_c,
  output logic               ce_n_o,
  output logic               oe_n_o,
  output logic               we_n_o,
  output logic [SRAM_AW-1:0] addr_o,
  output logic [BE_W-1:0]    be_n_o,
  output logic               drive_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic [DATA_W-1:0]  rdata_o
);

  localparam int unsigned CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

  logic               active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               drive_q, drive_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [BE_W-1:0]    be_n_q, be_n_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  assign done_c = active_q && (cnt_q == CNT_W'(WAIT - 1));

  // Strobes drop at the start edge and rise at the edge that ends the last cycle.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    drive_d  = drive_q;
    addr_d   = addr_q;
    be_n_d   = be_n_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      ce_n_d   = 1'b0;
      oe_n_d   = cmd_i.we;
      we_n_d   = ~cmd_i.we;
      drive_d  = cmd_i.we;
      addr_d   = cmd_i.addr;
      be_n_d   = cmd_i.be_n;
      wdata_d  = cmd_i.wdata;
    end else if (done_c) begin
      active_d = 1'b0;
      ce_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
      drive_d  = 1'b0;
      if (!oe_n_q) rdata_d = bus_rdata_i;
    end else if (active_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr_i) rdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      drive_q  <= 1'b0;
      addr_q   <= '0;
      be_n_q   <= BE_NONE;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      drive_q  <= drive_d;
      addr_q   <= addr_d;
      be_n_q   <= be_n_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ce_n_o  = ce_n_q;
  assign oe_n_o  = oe_n_q;
  assign we_n_o  = we_n_q;
  assign addr_o  = addr_q;
  assign be_n_o  = be_n_q;
  assign drive_o = drive_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_controller.sv
// MEM-stage bus master for base SRAM, ext SRAM and UART; stalls the pipeline until ack.
// Optional macro UART_STATUS_EN maps the UART status byte at 0x1000_0005.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 2,
  parameter int unsigned UART_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [BE_W-1:0]    req_be_n,
  output logic               ack,
  output logic               stall_req,
  output logic [BE_W-1:0]    ram_be_n,
  output logic [USE_W-1:0]   mem_use,
  output logic [DATA_W-1:0]  data_base_out,
  output logic [DATA_W-1:0]  data_ext_out,
  output logic [BYTE_W-1:0]  uart_rd,
  inout  wire  [DATA_W-1:0]  base_ram_data,
  output logic [SRAM_AW-1:0] base_ram_addr,
  output logic [BE_W-1:0]    base_ram_be_n,
  output logic               base_ram_ce_n,
  output logic               base_ram_oe_n,
  output logic               base_ram_we_n,
  inout  wire  [DATA_W-1:0]  ext_ram_data,
  output logic [SRAM_AW-1:0] ext_ram_addr,
  output logic [BE_W-1:0]    ext_ram_be_n,
  output logic               ext_ram_ce_n,
  output logic               ext_ram_oe_n,
  output logic               ext_ram_we_n,
  output logic               uart_rdn,
  output logic               uart_wrn,
  input  logic               uart_dataready,
  input  logic               uart_tbre,
  input  logic               uart_tsre
);

`ifdef UART_STATUS_EN
  localparam logic STATUS_EN = 1'b1;
`else
  localparam logic STATUS_EN = 1'b0;
`endif

  localparam int unsigned UCNT_W = (UART_WAIT > 1) ? $clog2(UART_WAIT) : 1;

  state_e             state_q, state_d;
  target_e            tgt_c;
  logic [USE_W-1:0]   use_c;
  sram_cmd_t          cmd_c;
  logic               idle_req_c;
  logic               start_base_c, start_ext_c, clr_base_c;
  logic               base_done_c, ext_done_c;
  logic               base_drive, ext_drive;
  logic [DATA_W-1:0]  base_wdata, ext_wdata;
  logic [BYTE_W-1:0]  status_c;
  logic               uart_last_c;

  logic               ack_q, ack_d;
  logic [BE_W-1:0]    ram_be_n_q, ram_be_n_d;
  logic [USE_W-1:0]   mem_use_q, mem_use_d;
  logic [UCNT_W-1:0]  uart_cnt_q, uart_cnt_d;
  logic               uart_rdn_q, uart_rdn_d;
  logic               uart_wrn_q, uart_wrn_d;
  logic               uart_drive_q, uart_drive_d;
  logic [BYTE_W-1:0]  uart_wdata_q, uart_wdata_d;
  logic [BYTE_W-1:0]  uart_rd_q, uart_rd_d;

  assign tgt_c        = decode_target(req_addr, STATUS_EN);
  assign use_c        = use_of(tgt_c, req_addr);
  assign cmd_c        = {req_we, req_addr[SRAM_AW+1:2], req_be_n, req_wdata};
  assign idle_req_c   = (state_q == ST_IDLE) && req;
  assign start_base_c = idle_req_c && (tgt_c == TGT_BASE);
  assign start_ext_c  = idle_req_c && (tgt_c == TGT_EXT);
  assign clr_base_c   = idle_req_c && (tgt_c == TGT_NONE) && !req_we && (use_c == USE_BASE);
  assign status_c     = {2'b00, uart_tbre & uart_tsre, 4'b0000, uart_dataready};
  assign uart_last_c  = (uart_cnt_q == UCNT_W'(UART_WAIT - 1));

  mem_controller_sram_port #(.WAIT(SRAM_WAIT)) u_base_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_base_c),
    .cmd_i       (cmd_c),
    .clr_i       (clr_base_c),
    .bus_rdata_i (base_ram_data),
    .done_c      (base_done_c),
    .ce_n_o      (base_ram_ce_n),
    .oe_n_o      (base_ram_oe_n),
    .we_n_o      (base_ram_we_n),
    .addr_o      (base_ram_addr),
    .be_n_o      (base_ram_be_n),
    .drive_o     (base_drive),
    .wdata_o     (base_wdata),
    .rdata_o     (data_base_out)
  );

  mem_controller_sram_port #(.WAIT(SRAM_WAIT)) u_ext_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_ext_c),
    .cmd_i       (cmd_c),
    .clr_i       (1'b0),
    .bus_rdata_i (ext_ram_data),
    .done_c      (ext_done_c),
    .ce_n_o      (ext_ram_ce_n),
    .oe_n_o      (ext_ram_oe_n),
    .we_n_o      (ext_ram_we_n),
    .addr_o      (ext_ram_addr),
    .be_n_o      (ext_ram_be_n),
    .drive_o     (ext_drive),
    .wdata_o     (ext_wdata),
    .rdata_o     (data_ext_out)
  );

  // Base bus low byte is shared with the UART data lines.
  assign base_ram_data = base_drive   ? base_wdata :
                         uart_drive_q ? {{(DATA_W-BYTE_W){1'bz}}, uart_wdata_q} :
                                        {DATA_W{1'bz}};
  assign ext_ram_data  = ext_drive ? ext_wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          case (tgt_c)
            TGT_BASE, TGT_EXT: state_d = req_we ? ST_SRAM_WR : ST_SRAM_RD;
            TGT_UART_DATA:     state_d = req_we ? ST_UART_WR : ST_UART_RD;
            default:           state_d = ST_DONE;
          endcase
        end
      end
      ST_SRAM_RD, ST_SRAM_WR: if (base_done_c || ext_done_c) state_d = ST_DONE;
      ST_UART_RD:             if (uart_last_c) state_d = ST_DONE;
      ST_UART_WR:             if (uart_last_c) state_d = ST_UART_WR_WAIT;
      ST_UART_WR_WAIT:        if (uart_tsre) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d        = (state_d == ST_DONE);
    ram_be_n_d   = ram_be_n_q;
    mem_use_d    = mem_use_q;
    uart_cnt_d   = uart_cnt_q;
    uart_rdn_d   = uart_rdn_q;
    uart_wrn_d   = uart_wrn_q;
    uart_drive_d = uart_drive_q;
    uart_wdata_d = uart_wdata_q;
    uart_rd_d    = uart_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          ram_be_n_d = req_be_n;
          mem_use_d  = use_c;
          case (tgt_c)
            TGT_UART_DATA: begin
              uart_cnt_d   = '0;
              uart_rdn_d   = req_we;
              uart_wrn_d   = ~req_we;
              uart_drive_d = req_we;
              uart_wdata_d = req_wdata[BYTE_W-1:0];
            end
            TGT_UART_STAT: if (!req_we) uart_rd_d = status_c;
            TGT_NONE:      if (!req_we && (use_c == USE_UART)) uart_rd_d = '0;
            default: ;
          endcase
        end
      end
      ST_UART_RD: begin
        if (uart_last_c) begin
          uart_rdn_d = 1'b1;
          uart_rd_d  = base_ram_data[BYTE_W-1:0];
        end else begin
          uart_cnt_d = uart_cnt_q + UCNT_W'(1);
        end
      end
      ST_UART_WR: begin
        if (uart_last_c) begin
          uart_wrn_d   = 1'b1;
          uart_drive_d = 1'b0;
        end else begin
          uart_cnt_d = uart_cnt_q + UCNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      ram_be_n_q   <= BE_NONE;
      mem_use_q    <= USE_BASE;
      uart_cnt_q   <= '0;
      uart_rdn_q   <= 1'b1;
      uart_wrn_q   <= 1'b1;
      uart_drive_q <= 1'b0;
      uart_wdata_q <= '0;
      uart_rd_q    <= '0;
    end else begin
      ack_q        <= ack_d;
      ram_be_n_q   <= ram_be_n_d;
      mem_use_q    <= mem_use_d;
      uart_cnt_q   <= uart_cnt_d;
      uart_rdn_q   <= uart_rdn_d;
      uart_wrn_q   <= uart_wrn_d;
      uart_drive_q <= uart_drive_d;
      uart_wdata_q <= uart_wdata_d;
      uart_rd_q    <= uart_rd_d;
    end
  end

  assign ack       = ack_q;
  assign stall_req = req & ~ack_q;
  assign ram_be_n  = ram_be_n_q;
  assign mem_use   = mem_use_q;
  assign uart_rd   = uart_rd_q;
  assign uart_rdn  = uart_rdn_q;
  assign uart_wrn  = uart_wrn_q;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: directed requests push expectations,
// a negedge monitor measures strobes/stall and checks each ack.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be_n;
  logic        ack, stall_req;
  logic [3:0]  ram_be_n;
  logic [1:0]  mem_use;
  logic [31:0] data_base_out, data_ext_out;
  logic [7:0]  uart_rd;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready, uart_tbre, uart_tsre;
  logic [7:0]  uart_byte;

  localparam logic [1:0] U_BASE = 2'd0, U_EXT = 2'd1, U_UART = 2'd2;

  always #5 clk = ~clk;

  mem_controller dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be_n(req_be_n), .ack(ack), .stall_req(stall_req),
    .ram_be_n(ram_be_n), .mem_use(mem_use), .data_base_out(data_base_out),
    .data_ext_out(data_ext_out), .uart_rd(uart_rd),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  function automatic logic [31:0] base_model(input logic [19:0] a);
    return (a == 20'h00004) ? 32'hDEADBEEF : {12'h5A5, a};
  endfunction

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_model(base_ram_addr) :
                         (!uart_rdn) ? {24'bz, uart_byte} : 32'bz;
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? {12'hC3C, ext_ram_addr} : 32'bz;

  typedef struct {
    string       nm;
    logic [1:0]  mu;
    logic [3:0]  be_n;
    logic [31:0] base, ext;
    logic [7:0]  urd;
    int          stall, b_oe, b_we, b_ce, e_oe, e_we, e_ce, rdn, wrn;
    logic [31:0] wbus;
    logic [19:0] addr;
    logic [3:0]  sbe;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] m_base = 0, m_ext = 0;
  logic [7:0]  m_urd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t dflt(input string nm);
    exp_t e;
    e.nm = nm; e.mu = U_BASE; e.be_n = 4'hF;
    e.base = m_base; e.ext = m_ext; e.urd = m_urd;
    e.stall = 0; e.b_oe = 0; e.b_we = 0; e.b_ce = 0;
    e.e_oe = 0; e.e_we = 0; e.e_ce = 0; e.rdn = 0; e.wrn = 0;
    e.wbus = 0; e.addr = 0; e.sbe = 4'hF;
    return e;
  endfunction

  // Monitor: accumulate per-transaction observations, compare on each ack.
  int          o_stall, o_boe, o_bwe, o_bce, o_eoe, o_ewe, o_ece, o_rdn, o_wrn;
  logic [31:0] o_wbus;
  logic [19:0] o_addr;
  logic [3:0]  o_sbe;

  task automatic clr_obs();
    o_stall = 0; o_boe = 0; o_bwe = 0; o_bce = 0; o_eoe = 0; o_ewe = 0;
    o_ece = 0; o_rdn = 0; o_wrn = 0; o_wbus = 0; o_addr = 0; o_sbe = 4'hF;
  endtask

  initial begin
    exp_t e;
    clr_obs();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clr_obs();
      end else begin
        if (stall_req)      o_stall++;
        if (!base_ram_oe_n) o_boe++;
        if (!base_ram_we_n) begin o_bwe++; o_wbus = base_ram_data; end
        if (!base_ram_ce_n) begin o_bce++; o_addr = base_ram_addr; o_sbe = base_ram_be_n; end
        if (!ext_ram_oe_n)  o_eoe++;
        if (!ext_ram_we_n)  begin o_ewe++; o_wbus = ext_ram_data; end
        if (!ext_ram_ce_n)  begin o_ece++; o_addr = ext_ram_addr; o_sbe = ext_ram_be_n; end
        if (!uart_rdn)      o_rdn++;
        if (!uart_wrn)      begin o_wrn++; o_wbus = {24'h0, base_ram_data[7:0]}; end
        if (ack) begin
          if (sb.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk({e.nm, ".mem_use"},  32'(mem_use), 32'(e.mu));
            chk({e.nm, ".ram_be_n"}, 32'(ram_be_n), 32'(e.be_n));
            chk({e.nm, ".data_base"}, data_base_out, e.base);
            chk({e.nm, ".data_ext"},  data_ext_out, e.ext);
            chk({e.nm, ".uart_rd"},  32'(uart_rd), 32'(e.urd));
            chk({e.nm, ".stall_cyc"}, 32'(o_stall), 32'(e.stall));
            chk({e.nm, ".base_oe_cyc"}, 32'(o_boe), 32'(e.b_oe));
            chk({e.nm, ".base_we_cyc"}, 32'(o_bwe), 32'(e.b_we));
            chk({e.nm, ".base_ce_cyc"}, 32'(o_bce), 32'(e.b_ce));
            chk({e.nm, ".ext_oe_cyc"},  32'(o_eoe), 32'(e.e_oe));
            chk({e.nm, ".ext_we_cyc"},  32'(o_ewe), 32'(e.e_we));
            chk({e.nm, ".ext_ce_cyc"},  32'(o_ece), 32'(e.e_ce));
            chk({e.nm, ".rdn_cyc"},  32'(o_rdn), 32'(e.rdn));
            chk({e.nm, ".wrn_cyc"},  32'(o_wrn), 32'(e.wrn));
            chk({e.nm, ".wbus"},     o_wbus, e.wbus);
            chk({e.nm, ".sram_addr"}, 32'(o_addr), 32'(e.addr));
            chk({e.nm, ".sram_be_n"}, 32'(o_sbe), 32'(e.sbe));
          end
          clr_obs();
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be_n, input exp_t e, input int tsre_delay);
    int   cyc;
    logic got;
    sb.push_back(e);
    @(posedge clk); #2;
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be_n = be_n;
    if (tsre_delay > 0) uart_tsre = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 64) begin
      @(posedge clk); #2;
      cyc++;
      if (ack) got = 1'b1;
      else if (cyc == tsre_delay) uart_tsre = 1'b1;
    end
    req = 1'b0; uart_tsre = 1'b1;
    chk({e.nm, ".ack_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0; req_be_n = 4'hF;
    uart_dataready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1; uart_byte = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.ram_be_n", 32'(ram_be_n), 32'hF);
    chk("rst.mem_use", 32'(mem_use), 32'(U_BASE));
    chk("rst.data_base", data_base_out, 32'd0);
    chk("rst.uart_rd", 32'(uart_rd), 32'd0);
    chk("rst.strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n,
                            ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn}), 32'hFF);
    rst_n = 1'b1;

    m_base = 32'hDEADBEEF;
    e = dflt("ld_base"); e.be_n = 4'h0; e.stall = 3; e.b_oe = 2; e.b_ce = 2;
    e.addr = 20'h00004; e.sbe = 4'h0;
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, e, 0);

    e = dflt("st_base_word"); e.be_n = 4'h0; e.stall = 3; e.b_we = 2; e.b_ce = 2;
    e.wbus = 32'h12345678; e.addr = 20'h00004; e.sbe = 4'h0;
    do_req(1'b1, 32'h8000_0010, 32'h12345678, 4'h0, e, 0);

    e = dflt("st_ext_byte"); e.mu = U_EXT; e.be_n = 4'b0111; e.stall = 3; e.e_we = 2;
    e.e_ce = 2; e.wbus = 32'hAB000000; e.addr = 20'h0; e.sbe = 4'b0111;
    do_req(1'b1, 32'h8040_0003, 32'hAB000000, 4'b0111, e, 0);

    m_ext = 32'hC3C00040;
    e = dflt("ld_ext"); e.mu = U_EXT; e.be_n = 4'h0; e.stall = 3; e.e_oe = 2; e.e_ce = 2;
    e.addr = 20'h00040; e.sbe = 4'h0;
    do_req(1'b0, 32'h8040_0100, 32'h0, 4'h0, e, 0);

    e = dflt("uart_wr"); e.mu = U_UART; e.be_n = 4'b1110; e.stall = 6; e.wrn = 2;
    e.wbus = 32'h41;
    do_req(1'b1, 32'h1000_0000, 32'h41, 4'b1110, e, 5);

    uart_byte = 8'h80; m_urd = 8'h80;
    e = dflt("uart_rd"); e.mu = U_UART; e.be_n = 4'b1110; e.stall = 3; e.rdn = 2;
    do_req(1'b0, 32'h1000_0000, 32'h0, 4'b1110, e, 0);

    uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
`ifdef UART_STATUS_EN
    m_urd = 8'h21;
`else
    m_urd = 8'h00;
`endif
    e = dflt("stat_rd"); e.mu = U_UART; e.be_n = 4'b1101; e.stall = 1;
    do_req(1'b0, 32'h1000_0005, 32'h0, 4'b1101, e, 0);

    e = dflt("stat_st"); e.mu = U_UART; e.be_n = 4'b1101; e.stall = 1;
    do_req(1'b1, 32'h1000_0005, 32'h0000_5500, 4'b1101, e, 0);

    e = dflt("unmapped_st"); e.mu = U_BASE; e.be_n = 4'h0; e.stall = 1;
    do_req(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'h0, e, 0);

    m_base = 32'h0;
    e = dflt("unmapped_ld"); e.mu = U_BASE; e.be_n = 4'h0; e.stall = 1;
    do_req(1'b0, 32'h2000_0000, 32'h0, 4'h0, e, 0);

    // Reset in the second SRAM_RD cycle abandons the access.
    @(posedge clk); #2;
    req = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0020; req_be_n = 4'h0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("midrst.oe_low_before", 32'(base_ram_oe_n), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("midrst.strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n}), 32'h7);
    chk("midrst.ack", 32'(ack), 32'd0);
    chk("midrst.ram_be_n", 32'(ram_be_n), 32'hF);
    chk("midrst.data_ext", data_ext_out, 32'd0);
    req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    m_base = 0; m_ext = 0; m_urd = 0;

    m_base = 32'h5A500008;
    e = dflt("ld_after_rst"); e.be_n = 4'h0; e.stall = 3; e.b_oe = 2; e.b_ce = 2;
    e.addr = 20'h00008; e.sbe = 4'h0;
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, e, 0);

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
